// File: rtl/hdmipixset_if.sv
// Wishbone slave bus for the HDMI pixel-injection block.
interface hdmipixset_if;
  logic        i_wb_cyc;
  logic        i_wb_stb;
  logic        i_wb_we;
  logic [1:0]  i_wb_addr;
  logic [31:0] i_wb_data;
  logic        o_wb_stall;
  logic        o_wb_ack;
  logic [31:0] o_wb_data;

  modport master (
    output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data,
    input  o_wb_stall, o_wb_ack, o_wb_data
  );

  modport slave (
    input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data,
    output o_wb_stall, o_wb_ack, o_wb_data
  );
endinterface

// File: rtl/hdmipixset.sv
// Substitutes a bus-programmed RGB pixel at one (frame-clock, pixel) position,
// either once (armed) or every frame (continuous).
module hdmipixset #(
  parameter int CLKBITS = 30
) (
  input  logic         i_clk,
  input  logic         i_reset,
  hdmipixset_if.slave  wb,
  input  logic [9:0]   i_hdmi_r,
  input  logic [9:0]   i_hdmi_g,
  input  logic [9:0]   i_hdmi_b,
  output logic [9:0]   o_hdmi_r,
  output logic [9:0]   o_hdmi_g,
  output logic [9:0]   o_hdmi_b
);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CONT} state_t;

  state_t               state, state_nxt;
  logic [CLKBITS-1:0]   frame_clks, frame_pixel, counter;
  logic [29:0]          pix_value;
  logic                 done;
  logic [15:0]          count;
  logic                 wr, ctrl_wr, match, hit, is_armed, is_cont;
  logic                 unused_bits;

  assign wr          = wb.i_wb_stb && wb.i_wb_we;
  assign ctrl_wr     = wr && (wb.i_wb_addr == 2'd3);
  assign match       = (counter == frame_pixel);
  assign wb.o_wb_stall = 1'b0;
  assign unused_bits = &{1'b0, wb.i_wb_data[31:30]};

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Next-state: a control write overrides the armed-hit return to idle
  always_comb begin
    state_nxt = state;
    if (ctrl_wr) begin
      if (wb.i_wb_data[1])      state_nxt = S_CONT;
      else if (wb.i_wb_data[0]) state_nxt = S_ARMED;
      else                      state_nxt = S_IDLE;
    end else if (state == S_ARMED && match) begin
      state_nxt = S_IDLE;
    end
  end

  always_comb begin
    is_armed = 1'b0;
    is_cont  = 1'b0;
    case (state)
      S_ARMED: is_armed = 1'b1;
      S_CONT:  is_cont  = 1'b1;
      default: ;
    endcase
    hit = match && (is_armed || is_cont);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      frame_clks  <= '0;
      frame_pixel <= '0;
      pix_value   <= '0;
      counter     <= '0;
      done        <= 1'b0;
      count       <= '0;
    end else begin
      if (wr && wb.i_wb_addr == 2'd0) counter <= '0;
      else if (counter < frame_clks)  counter <= counter + CLKBITS'(1);
      else                            counter <= '0;

      if (wr) begin
        case (wb.i_wb_addr)
          2'd0:    frame_clks  <= wb.i_wb_data[CLKBITS-1:0];
          2'd1:    frame_pixel <= wb.i_wb_data[CLKBITS-1:0];
          2'd2:    pix_value   <= wb.i_wb_data[29:0];
          default: ;
        endcase
      end

      // Control write clearing takes priority over the hit bookkeeping
      if (ctrl_wr) begin
        done  <= 1'b0;
        count <= '0;
      end else begin
        if (hit && is_armed)         done  <= 1'b1;
        if (hit && count != 16'hFFFF) count <= count + 16'd1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      {o_hdmi_r, o_hdmi_g, o_hdmi_b} <= '0;
      wb.o_wb_ack  <= 1'b0;
      wb.o_wb_data <= '0;
    end else begin
      {o_hdmi_r, o_hdmi_g, o_hdmi_b} <= hit ? pix_value : {i_hdmi_r, i_hdmi_g, i_hdmi_b};
      wb.o_wb_ack <= wb.i_wb_stb && wb.i_wb_cyc;
      case (wb.i_wb_addr)
        2'd0:    wb.o_wb_data <= 32'(frame_clks);
        2'd1:    wb.o_wb_data <= 32'(frame_pixel);
        2'd2:    wb.o_wb_data <= {2'b00, pix_value};
        default: wb.o_wb_data <= {count, 13'b0, done, is_cont, is_armed};
      endcase
    end
  end

endmodule

// File: tb/tb_hdmipixset.sv
// Randomized scoreboard bench for hdmipixset against a cycle-level reference model.
module tb_hdmipixset;
  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] ir, ig, ib, orr, og, ob;

  hdmipixset_if wb();

  hdmipixset #(.CLKBITS(30)) dut (
    .i_clk(clk), .i_reset(rst), .wb(wb),
    .i_hdmi_r(ir), .i_hdmi_g(ig), .i_hdmi_b(ib),
    .o_hdmi_r(orr), .o_hdmi_g(og), .o_hdmi_b(ob)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [29:0] pix;
    logic        ack;
    logic [31:0] data;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int subs   = 0;

  // Reference model: mode 0 idle, 1 fire once, 2 fire every frame
  logic [29:0] m_fc, m_fp, m_cnt, m_pix;
  int          m_mode;
  bit          m_done;
  int unsigned m_count;

  always @(posedge clk) begin
    exp_t e;
    bit   hit;
    if (rst) begin
      e = '0;
      m_fc = '0; m_fp = '0; m_cnt = '0; m_pix = '0;
      m_mode = 0; m_done = 0; m_count = 0;
    end else begin
      hit = (m_cnt == m_fp) && (m_mode != 0);
      if (hit) subs++;
      e.pix = hit ? m_pix : {ir, ig, ib};
      e.ack = wb.i_wb_stb && wb.i_wb_cyc;
      case (wb.i_wb_addr)
        2'd0: e.data = {2'b00, m_fc};
        2'd1: e.data = {2'b00, m_fp};
        2'd2: e.data = {2'b00, m_pix};
        default: e.data = {m_count[15:0], 13'b0, m_done, m_mode == 2, m_mode == 1};
      endcase
      if (hit && m_mode == 1) begin m_mode = 0; m_done = 1; end
      if (hit && m_count < 65535) m_count++;
      m_cnt = (m_cnt >= m_fc) ? 30'd0 : m_cnt + 30'd1;
      if (wb.i_wb_stb && wb.i_wb_we) begin
        case (wb.i_wb_addr)
          2'd0: begin m_fc = wb.i_wb_data[29:0]; m_cnt = '0; end
          2'd1: m_fp  = wb.i_wb_data[29:0];
          2'd2: m_pix = wb.i_wb_data[29:0];
          default: begin
            m_mode  = wb.i_wb_data[1] ? 2 : (wb.i_wb_data[0] ? 1 : 0);
            m_done  = 0;
            m_count = 0;
          end
        endcase
      end
    end
    q.push_back(e);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("pixel", {2'b00, orr, og, ob}, {2'b00, e.pix});
      check("ack", {31'b0, wb.o_wb_ack}, {31'b0, e.ack});
      check("rdata", wb.o_wb_data, e.data);
      check("stall", {31'b0, wb.o_wb_stall}, 32'd0);
    end
  end

  logic [29:0] pix_in;
  bit          rand_pix = 1'b1;

  // One bus/pixel cycle; inputs change on the falling edge
  task automatic cyc(input bit c, input bit s, input bit w, input logic [1:0] a, input logic [31:0] d);
    wb.i_wb_cyc = c; wb.i_wb_stb = s; wb.i_wb_we = w; wb.i_wb_addr = a; wb.i_wb_data = d;
    if (rand_pix) pix_in = 30'($urandom);
    {ir, ig, ib} = pix_in;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 2'($urandom), 32'($urandom));
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    cyc(1, 1, 1, a, d);
  endtask

  task automatic rd(input logic [1:0] a);
    cyc(1, 1, 0, a, 32'($urandom));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
  endtask

  int s0;

  initial begin
    rst = 1'b1;
    wb.i_wb_cyc = 0; wb.i_wb_stb = 0; wb.i_wb_we = 0; wb.i_wb_addr = 0; wb.i_wb_data = 0;
    {ir, ig, ib} = '0;
    @(negedge clk);
    idle(2);
    rst = 1'b0;

    // Free run with a constant pixel, reads of every register
    rand_pix = 1'b0; pix_in = 30'h1;
    for (int i = 0; i < 25; i++) begin
      rd(2'(i));
      idle(3);
    end
    rand_pix = 1'b1;

    // Continuous injection
    s0 = subs;
    wr(1, 32'd4); wr(2, 32'h3FF00FF); wr(3, 32'd2); wr(0, 32'd9);
    idle(29);
    rd(3); idle(1);
    check("cont_subs", 32'(subs - s0), 32'd3);

    // Armed: one substitution only
    s0 = subs;
    wr(3, 32'd1); wr(0, 32'd9);
    idle(55);
    rd(3); idle(1);
    check("armed_subs", 32'(subs - s0), 32'd1);

    // Target beyond frame period: never fires
    s0 = subs;
    wr(1, 32'd12); wr(3, 32'd1);
    idle(50);
    rd(3); idle(1);
    check("far_subs", 32'(subs - s0), 32'd0);

    // Control write lands on the same cycle as the armed hit
    s0 = subs;
    wr(1, 32'd4); wr(3, 32'd1); wr(0, 32'd9);
    idle(4);
    wr(3, 32'd0);
    idle(20);
    rd(3); idle(1);
    check("coincide_subs", 32'(subs - s0), 32'd1);

    // Reset mid-frame while continuous
    wr(1, 32'd3); wr(3, 32'd2); wr(0, 32'd7);
    idle(5);
    do_reset();
    s0 = subs;
    for (int i = 0; i < 4; i++) begin rd(2'(i)); idle(4); end
    check("post_reset_subs", 32'(subs - s0), 32'd0);

    // Shrink frame period below the running counter
    wr(0, 32'd15); wr(1, 32'd2); wr(3, 32'd2);
    idle(12);
    wr(0, 32'd3);
    idle(12);

    // Randomized mix of writes, reads, strobes without cycle, and resets
    for (int i = 0; i < 600; i++) begin
      int r;
      r = $urandom_range(99);
      if (r < 3) do_reset();
      else if (r < 15) begin
        logic [1:0] a;
        logic [31:0] d;
        a = 2'($urandom);
        case (a)
          2'd0: d = 32'($urandom_range(12));
          2'd1: d = 32'($urandom_range(14));
          2'd2: d = $urandom;
          default: d = 32'($urandom_range(3));
        endcase
        cyc($urandom_range(1), 1, 1, a, d);
      end else if (r < 40) cyc($urandom_range(1), 1, 0, 2'($urandom), $urandom);
      else idle(1);
    end

    idle(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
